// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60Hz VGA raster timing generator with delayed syncs and frame counter
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1,
  parameter int FRAME_W    = 16
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output logic [9:0]         DrawX,
  output logic [9:0]         DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACTIVE = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACTIVE = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       blank_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       start_next;

  // Next raster position and its decodes; registering these keeps the
  // decoded outputs cycle-aligned with the counter outputs.
  always_comb begin
    hc_next    = hc + 10'd1;
    vc_next    = vc;
    if (hc == H_LAST) begin
      hc_next = 10'd0;
      vc_next = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end
    blank_next = (hc_next < H_ACTIVE) && (vc_next < V_ACTIVE);
    hsync_next = !((hc_next >= HS_FIRST) && (hc_next <= HS_LAST));
    vsync_next = !((vc_next >= VS_FIRST) && (vc_next <= VS_LAST));
    start_next = (hc_next == 10'd0) && (vc_next == 10'd0);
  end

  // Counters and registered decodes; reset parks at the last pixel so the
  // first clock after release lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      blank       <= 1'b0;
      hsync_raw   <= 1'b1;
      vsync_raw   <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hc          <= hc_next;
      vc          <= vc_next;
      blank       <= blank_next;
      hsync_raw   <= hsync_next;
      vsync_raw   <= vsync_next;
      frame_start <= start_next;
      if (start_next) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  // Sync outputs lag the counters to line up with the downstream RGB registers.
  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      assign hs = hsync_raw;
      assign vs = vsync_raw;
    end else begin : g_sync_delay
      logic [SYNC_DELAY-1:0] hs_taps;
      logic [SYNC_DELAY-1:0] vs_taps;
      if (SYNC_DELAY == 1) begin : g_one
        // Single register stage behind the raw syncs.
        always_ff @(posedge vga_clk or negedge reset_n) begin
          if (!reset_n) begin
            hs_taps <= 1'b1;
            vs_taps <= 1'b1;
          end else begin
            hs_taps <= hsync_raw;
            vs_taps <= vsync_raw;
          end
        end
      end else begin : g_many
        // Multi-stage shift register behind the raw syncs.
        always_ff @(posedge vga_clk or negedge reset_n) begin
          if (!reset_n) begin
            hs_taps <= '1;
            vs_taps <= '1;
          end else begin
            hs_taps <= {hs_taps[SYNC_DELAY-2:0], hsync_raw};
            vs_taps <= {vs_taps[SYNC_DELAY-2:0], vsync_raw};
          end
        end
      end
      assign hs = hs_taps[SYNC_DELAY-1];
      assign vs = vs_taps[SYNC_DELAY-1];
    end
  endgenerate

endmodule
